// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one instruction-memory read at a time and hands the
// fetched word to decode over valid/ready. Build option: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    output logic             Imem_Req_Valid,
    input  logic             Imem_Req_Ready,
    output logic [31:0]      Imem_Addr,
    input  logic             Imem_Rsp_Valid,
    input  logic [31:0]      Imem_Rsp_Data,
    output logic [31:0]      Instr,
    output logic [31:0]      Instr_Pc,
    output logic [6:0]       Opcode,
    output logic             Instr_Valid,
    input  logic             Instr_Ready,
    input  logic             Pc_Src,
    input  logic [31:0]      Pc_Target,
    output logic [CNT_W-1:0] Instr_Count,
    output logic             Fetch_Fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;
    logic               req_valid;
    logic               instr_valid;
    logic [CNT_W-1:0]   count;
    logic [31:0]        next_pc;

    // Target low bits are dropped so the PC can never become misaligned.
    always_comb begin
        next_pc = Pc_Src ? (Pc_Target & 32'hFFFF_FFFC) : (pc + 32'd4);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault;
    logic misaligned;

    always_comb begin
        misaligned = Pc_Src && (Pc_Target[1:0] != 2'b00);
    end

    assign Fetch_Fault = fault;
`else
    assign Fetch_Fault = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_pc    <= RESET_PC;
            req_valid   <= 1'b0;
            instr_valid <= 1'b0;
            count       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault       <= 1'b0;
`endif
        end else begin
            case (state)
                REQ: begin
                    // Request stays up with a stable address until the memory takes it.
                    if (req_valid && Imem_Req_Ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        req_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (Imem_Rsp_Valid) begin
                        instr       <= Imem_Rsp_Data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (Instr_Ready) begin
                        instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else
`endif
                        begin
                            pc        <= next_pc;
                            count     <= count + CNT_W'(1);
                            req_valid <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                default: begin
                    // Trapped: only reset leaves this state.
                    req_valid   <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= FAULT;
                end
            endcase
        end
    end

    assign Imem_Req_Valid = req_valid;
    assign Imem_Addr      = pc;
    assign Instr          = instr;
    assign Instr_Pc       = instr_pc;
    assign Opcode         = instr[6:0];
    assign Instr_Valid    = instr_valid;
    assign Instr_Count    = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a second instance with RESET_PC at the top of
// memory runs in lockstep to cover PC wrap-around.
module tb_instr_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Imem_Req_Valid;
    logic        Imem_Req_Ready;
    logic [31:0] Imem_Addr;
    logic        Imem_Rsp_Valid;
    logic [31:0] Imem_Rsp_Data;
    logic [31:0] Instr;
    logic [31:0] Instr_Pc;
    logic [6:0]  Opcode;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Pc_Src;
    logic [31:0] Pc_Target;
    logic [31:0] Instr_Count;
    logic        Fetch_Fault;

    logic        w_req_valid;
    logic [31:0] w_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic [6:0]  w_opcode;
    logic        w_instr_valid;
    logic [31:0] w_count;
    logic        w_fault;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .Clk(Clk), .Rst(Rst),
        .Imem_Req_Valid(Imem_Req_Valid), .Imem_Req_Ready(Imem_Req_Ready), .Imem_Addr(Imem_Addr),
        .Imem_Rsp_Valid(Imem_Rsp_Valid), .Imem_Rsp_Data(Imem_Rsp_Data),
        .Instr(Instr), .Instr_Pc(Instr_Pc), .Opcode(Opcode),
        .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
        .Pc_Src(Pc_Src), .Pc_Target(Pc_Target),
        .Instr_Count(Instr_Count), .Fetch_Fault(Fetch_Fault)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_wrap (
        .Clk(Clk), .Rst(Rst),
        .Imem_Req_Valid(w_req_valid), .Imem_Req_Ready(Imem_Req_Ready), .Imem_Addr(w_addr),
        .Imem_Rsp_Valid(w_rsp_valid), .Imem_Rsp_Data(w_rsp_data),
        .Instr(w_instr), .Instr_Pc(w_instr_pc), .Opcode(w_opcode),
        .Instr_Valid(w_instr_valid), .Instr_Ready(Instr_Ready),
        .Pc_Src(1'b0), .Pc_Target(32'h0000_0000),
        .Instr_Count(w_count), .Fetch_Fault(w_fault)
    );

    function automatic logic [31:0] memData(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: memData = 32'h0050_0093;
            32'h0000_0004: memData = 32'h0030_2023;
            32'h0000_0008: memData = 32'hFE00_0EE3;
            32'hFFFF_FFFC: memData = 32'h00A0_0113;
            default:       memData = 32'h0000_0013;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One clock with a 1-cycle-latency memory behind both instances.
    task automatic tick();
        logic        acc;
        logic        w_acc;
        logic [31:0] a;
        logic [31:0] wa;
        acc   = Imem_Req_Valid && Imem_Req_Ready && !Rst;
        w_acc = w_req_valid && Imem_Req_Ready && !Rst;
        a     = Imem_Addr;
        wa    = w_addr;
        @(posedge Clk);
        #1;
        Imem_Rsp_Valid = acc;
        Imem_Rsp_Data  = acc ? memData(a) : 32'hDEAD_BEEF;
        w_rsp_valid    = w_acc;
        w_rsp_data     = w_acc ? memData(wa) : 32'hDEAD_BEEF;
    endtask

    task automatic applyStimulus(input logic src, input logic [31:0] tgt, input logic rdy);
        Pc_Src      = src;
        Pc_Target   = tgt;
        Instr_Ready = rdy;
    endtask

    // Starts in REQ with the request up; returns one cycle after the decode handshake.
    task automatic runFetch(input logic [31:0] exp_instr, input logic [31:0] exp_pc,
                            input logic src, input logic [31:0] tgt, input string tag);
        tick();
        checkOutput({tag, "_req_drop"}, 32'(Imem_Req_Valid), 32'd0);
        tick();
        checkOutput({tag, "_valid"}, 32'(Instr_Valid), 32'd1);
        checkOutput({tag, "_instr"}, Instr, exp_instr);
        checkOutput({tag, "_instr_pc"}, Instr_Pc, exp_pc);
        applyStimulus(src, tgt, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h1234_5679, 1'b1);
    endtask

    initial begin
        Rst            = 1'b1;
        Imem_Req_Ready = 1'b1;
        Imem_Rsp_Valid = 1'b0;
        Imem_Rsp_Data  = 32'h0;
        w_rsp_valid    = 1'b0;
        w_rsp_data     = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        tick();

        checkOutput("rst_req_valid", 32'(Imem_Req_Valid), 32'd0);
        checkOutput("rst_addr", Imem_Addr, 32'h0);
        checkOutput("rst_instr", Instr, 32'h0000_0013);
        checkOutput("rst_opcode", 32'(Opcode), 32'h13);
        checkOutput("rst_instr_pc", Instr_Pc, 32'h0);
        checkOutput("rst_valid", 32'(Instr_Valid), 32'd0);
        checkOutput("rst_count", Instr_Count, 32'd0);
        checkOutput("rst_fault", 32'(Fetch_Fault), 32'd0);
        checkOutput("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

        Rst = 1'b0;
        tick();
        checkOutput("first_req_valid", 32'(Imem_Req_Valid), 32'd1);
        checkOutput("first_req_addr", Imem_Addr, 32'h0);

        runFetch(32'h0050_0093, 32'h0, 1'b0, 32'h0, "seq0");
        checkOutput("seq0_opcode", 32'(Opcode), 32'h13);
        checkOutput("seq0_valid_drop", 32'(Instr_Valid), 32'd0);
        checkOutput("seq0_next_addr", Imem_Addr, 32'h4);
        checkOutput("seq0_req_valid", 32'(Imem_Req_Valid), 32'd1);
        checkOutput("seq0_count", Instr_Count, 32'd1);
        checkOutput("wrap_instr", w_instr, 32'h00A0_0113);
        checkOutput("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_next_addr", w_addr, 32'h0);
        checkOutput("wrap_count", w_count, 32'd1);

        runFetch(32'h0030_2023, 32'h4, 1'b0, 32'h0, "seq1");
        checkOutput("seq1_opcode", 32'(Opcode), 32'h23);
        checkOutput("seq1_next_addr", Imem_Addr, 32'h8);
        checkOutput("seq1_count", Instr_Count, 32'd2);

        // Memory stalls the request, then decode stalls the instruction.
        Imem_Req_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_req_valid", 32'(Imem_Req_Valid), 32'd1);
            checkOutput("bp_req_addr", Imem_Addr, 32'h8);
            checkOutput("bp_req_no_instr", 32'(Instr_Valid), 32'd0);
        end
        Imem_Req_Ready = 1'b1;
        tick();
        checkOutput("bp_req_accepted", 32'(Imem_Req_Valid), 32'd0);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_hold_valid", 32'(Instr_Valid), 32'd1);
            checkOutput("bp_hold_instr", Instr, 32'hFE00_0EE3);
            checkOutput("bp_hold_pc", Instr_Pc, 32'h8);
            checkOutput("bp_hold_no_req", 32'(Imem_Req_Valid), 32'd0);
            checkOutput("bp_hold_count", Instr_Count, 32'd2);
            tick();
        end
        applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h1234_5679, 1'b1);
        checkOutput("br_taken_addr", Imem_Addr, 32'h0);
        checkOutput("br_taken_count", Instr_Count, 32'd3);
        checkOutput("br_taken_valid", 32'(Instr_Valid), 32'd0);
        checkOutput("br_instr_kept", Instr, 32'hFE00_0EE3);
        checkOutput("br_instr_pc_kept", Instr_Pc, 32'h8);

        runFetch(32'h0050_0093, 32'h0, 1'b0, 32'h0, "nt0");
        runFetch(32'h0030_2023, 32'h4, 1'b0, 32'h0, "nt1");
        runFetch(32'hFE00_0EE3, 32'h8, 1'b0, 32'h0, "nt2");
        checkOutput("br_not_taken_addr", Imem_Addr, 32'hC);
        checkOutput("br_not_taken_count", Instr_Count, 32'd6);

        // Reset while a response is pending.
        tick();
        checkOutput("mid_in_wait", 32'(Imem_Req_Valid), 32'd0);
        Rst = 1'b1;
        tick();
        checkOutput("mid_rst_valid", 32'(Instr_Valid), 32'd0);
        checkOutput("mid_rst_req_valid", 32'(Imem_Req_Valid), 32'd0);
        checkOutput("mid_rst_addr", Imem_Addr, 32'h0);
        checkOutput("mid_rst_instr", Instr, 32'h0000_0013);
        checkOutput("mid_rst_count", Instr_Count, 32'd0);
        Rst = 1'b0;
        tick();
        checkOutput("mid_first_req_valid", 32'(Imem_Req_Valid), 32'd1);
        checkOutput("mid_first_req_addr", Imem_Addr, 32'h0);

        runFetch(32'h0050_0093, 32'h0, 1'b1, 32'h0000_0006, "mis");
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("mis_fault", 32'(Fetch_Fault), 32'd1);
        checkOutput("mis_count", Instr_Count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mis_no_req", 32'(Imem_Req_Valid), 32'd0);
            checkOutput("mis_no_valid", 32'(Instr_Valid), 32'd0);
            tick();
        end
`else
        checkOutput("mis_fault", 32'(Fetch_Fault), 32'd0);
        checkOutput("mis_next_addr", Imem_Addr, 32'h4);
        checkOutput("mis_count", Instr_Count, 32'd1);
        checkOutput("mis_req_valid", 32'(Imem_Req_Valid), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
